// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ps2_key_tracker: PS/2 set-2 held/press/release tracker for a table of keys.
// Optional stuck-key watchdog enabled by defining PS2_KEY_TRACKER_WDOG_EN.
module ps2_key_tracker #(
    parameter int                    NUM_KEYS    = 4,
    parameter logic [NUM_KEYS*8-1:0] KEY_CODES   = {8'h23, 8'h1B, 8'h1C, 8'h1D},
    parameter logic [NUM_KEYS-1:0]   EXT_MASK    = '0,
    parameter int                    WDOG_CYCLES = 100_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scan_done_tick,
    input  logic [7:0]          scan_code,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic                any_held
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_PAUSE = 8'hE1;
    localparam logic [7:0] CODE_BAT   = 8'hAA;
    localparam logic [7:0] CODE_ACK   = 8'hFA;
    localparam logic [7:0] CODE_RSND  = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_SKIP    = 3'd4
    } state_t;

    state_t              state;
    logic [2:0]          skip_cnt;
    logic [NUM_KEYS-1:0] match_plain;
    logic [NUM_KEYS-1:0] match_ext;
    logic [NUM_KEYS-1:0] hit;
    logic [NUM_KEYS-1:0] make_set;
    logic [NUM_KEYS-1:0] brk_clr;
    logic [NUM_KEYS-1:0] held_next;
    logic [NUM_KEYS-1:0] rel_next;
    logic                is_prefix;
    logic                is_make;
    logic                is_break;
    logic                ext;
    logic                self_test;
    logic                wdog_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_match
            assign match_plain[gi] = (scan_code == KEY_CODES[8*gi +: 8]) && !EXT_MASK[gi];
            assign match_ext[gi]   = (scan_code == KEY_CODES[8*gi +: 8]) &&  EXT_MASK[gi];
        end
    endgenerate

    always_comb begin
        is_prefix = (scan_code == CODE_EXT) || (scan_code == CODE_BRK);
        is_make   = 1'b0;
        is_break  = 1'b0;
        ext       = 1'b0;
        self_test = 1'b0;
        if (scan_done_tick) begin
            case (state)
                S_IDLE: begin
                    self_test = (scan_code == CODE_BAT);
                    is_make   = !is_prefix && (scan_code != CODE_PAUSE) && (scan_code != CODE_BAT)
                                && (scan_code != CODE_ACK) && (scan_code != CODE_RSND);
                end
                S_EXT: begin
                    is_make = !is_prefix;
                    ext     = 1'b1;
                end
                S_BRK: is_break = !is_prefix;
                S_EXT_BRK: begin
                    is_break = !is_prefix;
                    ext      = 1'b1;
                end
                default: ;
            endcase
        end
        hit      = ext ? match_ext : match_plain;
        make_set = is_make  ? (hit & ~key_held) : '0;
        brk_clr  = is_break ? (hit &  key_held) : '0;
        // Watchdog releases with pulses; keyboard self-test clears silently.
        if (wdog_fire) begin
            held_next = '0;
            rel_next  = key_held;
        end else if (self_test) begin
            held_next = '0;
            rel_next  = '0;
        end else begin
            held_next = (key_held | make_set) & ~brk_clr;
            rel_next  = brk_clr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            skip_cnt      <= '0;
            key_held      <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            any_held      <= 1'b0;
        end else begin
            key_held      <= held_next;
            press_pulse   <= make_set;
            release_pulse <= rel_next;
            any_held      <= |held_next;
            if (wdog_fire) begin
                state <= S_IDLE;
            end else if (scan_done_tick) begin
                case (state)
                    S_IDLE: begin
                        if (scan_code == CODE_EXT) begin
                            state <= S_EXT;
                        end else if (scan_code == CODE_BRK) begin
                            state <= S_BRK;
                        end else if (scan_code == CODE_PAUSE) begin
                            state    <= S_SKIP;
                            skip_cnt <= 3'd7;
                        end
                    end
                    S_EXT: begin
                        if (scan_code == CODE_BRK)      state <= S_EXT_BRK;
                        else if (scan_code != CODE_EXT) state <= S_IDLE;
                    end
                    S_BRK: begin
                        if (scan_code == CODE_EXT)      state <= S_EXT_BRK;
                        else if (scan_code != CODE_BRK) state <= S_IDLE;
                    end
                    S_EXT_BRK: begin
                        if (!is_prefix) state <= S_IDLE;
                    end
                    S_SKIP: begin
                        skip_cnt <= skip_cnt - 3'd1;
                        if (skip_cnt == 3'd1) state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef PS2_KEY_TRACKER_WDOG_EN
    localparam int                WDOG_W    = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt;

    // Counter parks at its terminal value; only a new byte restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt <= '0;
        end else if (scan_done_tick) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WDOG_LAST) begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end

    assign wdog_fire = !scan_done_tick && any_held && (wdog_cnt == WDOG_LAST);
`else
    assign wdog_fire = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_tracker.sv
`default_nettype none
// tb_ps2_key_tracker: directed self-checking bench for ps2_key_tracker.
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_done_tick = 1'b0;
    logic [7:0] scan_code = 8'h00;

    logic [3:0] key_held, press_pulse, release_pulse;
    logic       any_held;
    logic [3:0] x_held, x_press, x_release;
    logic       x_any;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ps2_key_tracker #(.WDOG_CYCLES(50)) dut (
        .clk(clk), .reset(reset), .scan_done_tick(scan_done_tick), .scan_code(scan_code),
        .key_held(key_held), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .any_held(any_held)
    );

    // Key 3 remapped to extended 75 (E0 75).
    ps2_key_tracker #(
        .NUM_KEYS(4), .KEY_CODES(32'h751B1C1D), .EXT_MASK(4'b1000), .WDOG_CYCLES(50)
    ) dut_x (
        .clk(clk), .reset(reset), .scan_done_tick(scan_done_tick), .scan_code(scan_code),
        .key_held(x_held), .press_pulse(x_press), .release_pulse(x_release),
        .any_held(x_any)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Strobe one byte; returns at the negedge after the capturing posedge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_done_tick = 1'b1;
        scan_code      = b;
        @(negedge clk);
        scan_done_tick = 1'b0;
        scan_code      = 8'h00;
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        bit         seen;
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        repeat (3) @(negedge clk);
        check("rst_held", {28'd0, key_held}, 32'h0);
        check("rst_pulses", {24'd0, press_pulse, release_pulse}, 32'h0);
        check("rst_any", {31'd0, any_held}, 32'h0);
        reset = 1'b0;

        // Basic make/break of key0.
        send(8'h1D);
        check("mk_held", {28'd0, key_held}, 32'h1);
        check("mk_press", {28'd0, press_pulse}, 32'h1);
        check("mk_any", {31'd0, any_held}, 32'h1);
        @(negedge clk);
        check("mk_press_1cyc", {28'd0, press_pulse}, 32'h0);
        send(8'hF0);
        check("brk_prefix_held", {28'd0, key_held}, 32'h1);
        send(8'h1D);
        check("brk_held", {28'd0, key_held}, 32'h0);
        check("brk_release", {28'd0, release_pulse}, 32'h1);
        check("brk_any", {31'd0, any_held}, 32'h0);
        @(negedge clk);
        check("brk_release_1cyc", {28'd0, release_pulse}, 32'h0);

        // Typematic repeats.
        send(8'h1D);
        check("typ_press0", {28'd0, press_pulse}, 32'h1);
        send(8'h1C);
        check("typ_press1", {28'd0, press_pulse}, 32'h2);
        send(8'h1D);
        check("typ_rep1", {28'd0, press_pulse}, 32'h0);
        send(8'h1D);
        check("typ_rep2", {28'd0, press_pulse}, 32'h0);
        check("typ_held", {28'd0, key_held}, 32'h3);

        // Extended key on dut_x; non-extended 75 must not match.
        send(8'h75);
        check("x_plain75", {28'd0, x_held}, 32'h3);
        check("x_plain75_press", {28'd0, x_press}, 32'h0);
        send(8'hE0); send(8'h75);
        check("x_ext_held", {28'd0, x_held}, 32'hB);
        check("x_ext_press", {28'd0, x_press}, 32'h8);
        check("x_ext_dflt_held", {28'd0, key_held}, 32'h3);
        send(8'hE0); send(8'h1D);
        check("x_ext_key0_nomatch", {28'd0, x_press}, 32'h0);
        send(8'hE0); send(8'hF0); send(8'h75);
        check("x_extbrk_held", {28'd0, x_held}, 32'h3);
        check("x_extbrk_release", {28'd0, x_release}, 32'h8);

        // Release key1 via F0 F0 1C (repeated F0 stays in break state).
        send(8'hF0); send(8'hF0); send(8'h1C);
        check("brk2_held", {28'd0, key_held}, 32'h1);
        check("brk2_release", {28'd0, release_pulse}, 32'h2);

        // Pause sequence is swallowed.
        for (int i = 0; i < 8; i++) begin
            send(pause_seq[i]);
            check("pause_pulses", {24'd0, press_pulse, release_pulse}, 32'h0);
        end
        check("pause_held", {28'd0, key_held}, 32'h1);
        send(8'h1C);
        check("post_pause_held", {28'd0, key_held}, 32'h3);
        check("post_pause_press", {28'd0, press_pulse}, 32'h2);
        send(8'hFA);
        check("ack_ignored", {28'd0, key_held}, 32'h3);
        send(8'hAA);
        check("bat_held", {28'd0, key_held}, 32'h0);
        check("bat_no_release", {28'd0, release_pulse}, 32'h0);
        check("bat_any", {31'd0, any_held}, 32'h0);

        // Reset mid-prefix.
        send(8'h1B);
        check("pre_rst_held", {28'd0, key_held}, 32'h4);
        send(8'hE0); send(8'hF0);
        reset = 1'b1;
        #1;
        check("async_rst_held", {28'd0, key_held}, 32'h0);
        check("async_rst_any", {31'd0, any_held}, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_pulses2", {24'd0, press_pulse, release_pulse}, 32'h0);
        reset = 1'b0;
        send(8'h1D);
        check("post_rst_held", {28'd0, key_held}, 32'h1);
        check("post_rst_press", {28'd0, press_pulse}, 32'h1);

        // Idle with key0 held.
`ifdef PS2_KEY_TRACKER_WDOG_EN
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (release_pulse != 4'h0) seen = 1'b1;
        end
        check("wdog_fired", {31'd0, seen}, 32'h1);
        check("wdog_release", {28'd0, release_pulse}, 32'h1);
        check("wdog_held", {28'd0, key_held}, 32'h0);
`else
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (release_pulse != 4'h0) seen = 1'b1;
        end
        check("nowdog_release_seen", {31'd0, seen}, 32'h0);
        check("nowdog_held", {28'd0, key_held}, 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
